// File: rtl/clk_div_gen_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
// Helpers work on a wide ratio type so any channel width up to 15 bits can use them.
package clk_div_gen_pkg;

  localparam int DIV_W_DEF       = 5;
  localparam int DEFAULT_DIV_DEF = 16;
  localparam int RATIO_W         = 16;

  typedef logic [RATIO_W-1:0] ratio_t;

  // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
  function automatic ratio_t clamp_ratio(input ratio_t r);
    return (r < ratio_t'(2)) ? ratio_t'(2) : r;
  endfunction

  // High phase length ceil(R/2).
  function automatic ratio_t high_len(input ratio_t r);
    return ratio_t'((r + ratio_t'(1)) >> 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, pending-ratio handshake, boundary-sampled gate
// and registered clock/tick/ack outputs.
module clk_div_ch
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] ratio_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic             ack_o,
  output logic             clk_o,
  output logic             gated_o,
  output logic             tick_o,
  output logic             running_o
);

  localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_q, pend_d;
  logic             gate_q, gate_d;
  logic             started_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             gated_q, gated_d;
  logic             boundary;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    boundary     = !started_q || (cnt_q == (ratio_q - ONE));
    cnt_d        = cnt_q + ONE;
    ratio_d      = ratio_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    gate_d       = gate_q;
    ack_d        = 1'b0;

    // The first edge out of reset is treated as a boundary so period 0 starts there.
    if (boundary) begin
      cnt_d  = '0;
      gate_d = en_i;
      ack_d  = pend_q;
      if (pend_q) begin
        ratio_d = pend_ratio_q;
        pend_d  = 1'b0;
      end
    end

    // A load on a boundary edge lands after the swap above, so it waits one more period.
    if (load_i) begin
      pend_d       = 1'b1;
      pend_ratio_d = DIV_W'(clamp_ratio(ratio_t'(ratio_i)));
    end

    clk_d   = ratio_t'(cnt_d) < high_len(ratio_t'(ratio_d));
    tick_d  = boundary;
    gated_d = clk_d & gate_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      ratio_q      <= DEF_R;
      pend_ratio_q <= DEF_R;
      pend_q       <= 1'b0;
      gate_q       <= 1'b0;
      started_q    <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
      gated_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ratio_q      <= ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      gate_q       <= gate_d;
      started_q    <= 1'b1;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
      gated_q      <= gated_d;
    end
  end

  assign ack_o     = ack_q;
  assign clk_o     = clk_q;
  assign gated_o   = gated_q;
  assign tick_o    = tick_q;
  assign running_o = gate_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider and gate generator; slices the
// per-channel buses onto independent clk_div_ch instances.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*DIV_W-1:0] div_ratio,
  input  logic [N_CH-1:0]       div_load,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       div_ack,
  output logic [N_CH-1:0]       clk_div_out,
  output logic [N_CH-1:0]       clk_div_gated,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       running
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .ratio_i  (div_ratio[i*DIV_W +: DIV_W]),
      .load_i   (div_load[i]),
      .en_i     (ch_en[i]),
      .ack_o    (div_ack[i]),
      .clk_o    (clk_div_out[i]),
      .gated_o  (clk_div_gated[i]),
      .tick_o   (tick[i]),
      .running_o(running[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a behavioural period model queues expected
// outputs on each rising edge and the falling edge compares them with the DUT.
module tb_clk_div_gen;

  localparam int N_CH  = 2;
  localparam int DIV_W = 5;
  localparam int DEF   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*DIV_W-1:0] div_ratio;
  logic [N_CH-1:0]       div_load;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       div_ack;
  logic [N_CH-1:0]       clk_div_out;
  logic [N_CH-1:0]       clk_div_gated;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       running;

  clk_div_gen #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_ratio    (div_ratio),
    .div_load     (div_load),
    .ch_en        (ch_en),
    .div_ack      (div_ack),
    .clk_div_out  (clk_div_out),
    .clk_div_gated(clk_div_gated),
    .tick         (tick),
    .running      (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] tck;
    logic [N_CH-1:0] ack;
    logic [N_CH-1:0] gated;
    logic [N_CH-1:0] run;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_armed = 1'b0;

  // Behavioural model: position within the period, active/pending ratio, gate.
  bit m_started[N_CH];
  int m_pos[N_CH];
  int m_r[N_CH];
  bit m_pend[N_CH];
  int m_pend_r[N_CH];
  bit m_gate[N_CH];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_started[c] = 1'b0;
        m_pos[c]     = 0;
        m_r[c]       = DEF;
        m_pend[c]    = 1'b0;
        m_pend_r[c]  = DEF;
        m_gate[c]    = 1'b0;
      end else begin
        if (!m_started[c] || m_pos[c] == m_r[c] - 1) begin
          e.tck[c] = 1'b1;
          e.ack[c] = m_pend[c];
          if (m_pend[c]) m_r[c] = m_pend_r[c];
          m_pend[c]    = 1'b0;
          m_pos[c]     = 0;
          m_gate[c]    = ch_en[c];
          m_started[c] = 1'b1;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        if (div_load[c]) begin
          int v;
          v = int'((div_ratio >> (c * DIV_W)) & ((1 << DIV_W) - 1));
          m_pend[c]   = 1'b1;
          m_pend_r[c] = (v < 2) ? 2 : v;
        end
        e.out[c]   = (m_pos[c] < (m_r[c] + 1) / 2);
        e.gated[c] = e.out[c] & m_gate[c];
        e.run[c]   = m_gate[c];
      end
    end
    sb_q.push_back(e);
    sb_armed = 1'b1;
  end

  int ack_cnt[N_CH];

  always @(negedge clk) begin
    if (sb_armed) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("clk_div_out",   32'(clk_div_out),   32'(e.out));
        check("tick",          32'(tick),          32'(e.tck));
        check("div_ack",       32'(div_ack),       32'(e.ack));
        check("clk_div_gated", 32'(clk_div_gated), 32'(e.gated));
        check("running",       32'(running),       32'(e.run));
      end
    end
    for (int c = 0; c < N_CH; c++) if (div_ack[c] === 1'b1) ack_cnt[c]++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int c, input int p);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_pos[c] == p) return;
    end
    check("wait_pos_timeout", 32'(m_pos[c]), 32'(p));
  endtask

  task automatic load(input int c, input int v);
    div_ratio[c*DIV_W +: DIV_W] = DIV_W'(v);
    div_load[c] = 1'b1;
    @(negedge clk);
    div_load[c] = 1'b0;
  endtask

  task automatic clear_acks();
    for (int c = 0; c < N_CH; c++) ack_cnt[c] = 0;
  endtask

  int hi_run, lo_run, max_hi, max_lo;

  initial begin
    rst       = 1'b1;
    div_ratio = '0;
    div_load  = '0;
    ch_en     = '0;
    clear_acks();
    cycles(4);
    rst = 1'b0;

    // Default ratio 16, gate closed.
    cycles(40);

    // Ratio 5 loaded mid-period: one ack at the first new period.
    wait_pos(0, 3);
    clear_acks();
    load(0, 5);
    cycles(40);
    check("ack_once_r5", 32'(ack_cnt[0]), 32'd1);
    check("ch1_no_ack", 32'(ack_cnt[1]), 32'd0);

    // Clamped ratios then the maximum ratio.
    load(0, 0);
    cycles(20);
    load(0, 1);
    cycles(20);
    load(0, 31);
    max_hi = 0; max_lo = 0; hi_run = 0; lo_run = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clk_div_out[0]) begin hi_run++; lo_run = 0; end
      else begin lo_run++; hi_run = 0; end
      if (hi_run > max_hi) max_hi = hi_run;
      if (lo_run > max_lo) max_lo = lo_run;
    end
    check("r31_high_len", 32'(max_hi), 32'd16);
    check("r31_low_len",  32'(max_lo), 32'd15);

    // Two loads in one period: last wins, single ack.
    wait_pos(0, 2);
    clear_acks();
    load(0, 7);
    cycles(3);
    load(0, 9);
    cycles(60);
    check("ack_once_last_wins", 32'(ack_cnt[0]), 32'd1);

    // Gate open then close in the middle of the high phase.
    load(0, 16);
    cycles(40);
    wait_pos(0, 3);
    ch_en[0] = 1'b1;
    cycles(40);
    wait_pos(0, 3);
    ch_en[0] = 1'b0;
    cycles(40);

    // Reset while channel 1 has a pending load and channel 0 runs R=3.
    load(0, 3);
    cycles(20);
    wait_pos(1, 2);
    load(1, 20);
    rst = 1'b1;
    clear_acks();
    @(negedge clk);
    rst = 1'b0;
    cycles(40);
    check("rst_no_ack_ch0", 32'(ack_cnt[0]), 32'd0);
    check("rst_no_ack_ch1", 32'(ack_cnt[1]), 32'd0);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
